// File: rtl/irq_request_capture.sv
// Interrupt request front end: synchronizes four request lines, detects events
// (rising edge or level) and holds them pending until acknowledged by index.
module irq_request_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq_in,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic [1:0] ack_id,
    input  logic       clear_ovf,
    output logic [3:0] pending,
    output logic       req_valid,
    output logic [3:0] overflow
);

    localparam int unsigned NUM_IRQ = 4;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_r;
    logic [NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] hist_r;
    logic [NUM_IRQ-1:0] pend_r;
    logic [NUM_IRQ-1:0] event_c;
    logic [NUM_IRQ-1:0] clr_c;
    logic [NUM_IRQ-1:0] pend_nxt_c;
    logic [NUM_IRQ-1:0] ovf_set_c;
    logic [NUM_IRQ-1:0] ovf_nxt_c;
    logic [NUM_IRQ-1:0] vis_nxt_c;

    // Synchronizer chain; stage 0 samples the raw lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], irq_in};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    // Event detection, pending/overflow next state and the visible vector.
    always_comb begin
        event_c    = '0;
        clr_c      = '0;
        pend_nxt_c = '0;
        ovf_set_c  = '0;
        ovf_nxt_c  = '0;
        vis_nxt_c  = '0;

        if (EDGE_MODE) begin
            event_c = sync_q & ~hist_r;
        end else begin
            event_c = sync_q;
        end

        if (ack) begin
            clr_c[ack_id] = 1'b1;
        end

        // A new event always wins over a same-cycle acknowledge.
        pend_nxt_c = event_c | (pend_r & ~clr_c);
        ovf_set_c  = event_c & pend_r & ~clr_c;
        ovf_nxt_c  = ovf_set_c | (clear_ovf ? NUM_IRQ'(0) : overflow);
        vis_nxt_c  = pend_nxt_c & ~mask;
    end

    // State and output registers; outputs track next-state so they carry no extra lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r    <= '0;
            pend_r    <= '0;
            overflow  <= '0;
            pending   <= '0;
            req_valid <= 1'b0;
        end else begin
            hist_r    <= sync_q;
            pend_r    <= pend_nxt_c;
            overflow  <= ovf_nxt_c;
            pending   <= vis_nxt_c;
            req_valid <= |vis_nxt_c;
        end
    end

endmodule

// File: tb/tb_irq_request_capture.sv
// Bench for irq_request_capture: an edge-mode instance (2 sync stages) and a
// level-mode instance (3 sync stages) driven from per-cycle stimulus tables.
module tb_irq_request_capture;

    typedef struct {
        logic [3:0] irq;
        logic       ack;
        logic [1:0] id;
        logic       cov;
        logic [3:0] msk;
        logic [3:0] ep;
        logic       er;
        logic [3:0] eo;
    } step_t;

    typedef struct {
        logic [3:0] pend;
        logic       rv;
        logic [3:0] ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] irq_e = '0;
    logic       ack_e = 1'b0;
    logic [1:0] id_e = '0;
    logic [3:0] irq_l = '0;
    logic       ack_l = 1'b0;
    logic [1:0] id_l = '0;
    logic [3:0] mask = '0;
    logic       clear_ovf = 1'b0;

    logic [3:0] pending, overflow, pend_l, ovf_l;
    logic       req_valid, rv_l;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    irq_request_capture #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_e), .mask(mask), .ack(ack_e),
        .ack_id(id_e), .clear_ovf(clear_ovf), .pending(pending),
        .req_valid(req_valid), .overflow(overflow)
    );

    irq_request_capture #(.SYNC_STAGES(3), .EDGE_MODE(1'b0)) dut_lvl (
        .clk(clk), .rst(rst), .irq_in(irq_l), .mask(mask), .ack(ack_l),
        .ack_id(id_l), .clear_ovf(clear_ovf), .pending(pend_l),
        .req_valid(rv_l), .overflow(ovf_l)
    );

    function automatic step_t st(input logic [3:0] irq, input logic ack, input logic [1:0] id,
                                 input logic cov, input logic [3:0] msk,
                                 input logic [3:0] ep, input logic er, input logic [3:0] eo);
        step_t s;
        s.irq = irq; s.ack = ack; s.id = id; s.cov = cov; s.msk = msk;
        s.ep = ep; s.er = er; s.eo = eo;
        return s;
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic apply(input step_t s, input bit lvl);
        exp_t e;
        irq_e     = lvl ? 4'b0000 : s.irq;
        ack_e     = lvl ? 1'b0 : s.ack;
        id_e      = lvl ? 2'b00 : s.id;
        irq_l     = lvl ? s.irq : 4'b0000;
        ack_l     = lvl ? s.ack : 1'b0;
        id_l      = lvl ? s.id : 2'b00;
        mask      = s.msk;
        clear_ovf = s.cov;
        e.pend = s.ep; e.rv = s.er; e.ovf = s.eo;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        step_t s[$];
        exp_t  e;
        rst = 1'b1;
        irq_e = '0; irq_l = '0; ack_e = 1'b0; ack_l = 1'b0; mask = '0; clear_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pending, req_valid, overflow, pend_l, rv_l, ovf_l} !== 18'b0) begin
            errors++;
            $display("FAIL reset_hold: got pend=%b rv=%b ovf=%b lvl pend=%b rv=%b ovf=%b, want all 0",
                     pending, req_valid, overflow, pend_l, rv_l, ovf_l);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) s.push_back(st(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0));
        foreach (s[k]) begin
            apply(s[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (pending !== e.pend || req_valid !== e.rv || overflow !== e.ovf) begin
                errors++;
                $display("FAIL reset_idle step %0d: got pend=%b rv=%b ovf=%b, want pend=%b rv=%b ovf=%b",
                         k, pending, req_valid, overflow, e.pend, e.rv, e.ovf);
            end
        end
    endtask

    task automatic test_edge_latency();
        step_t s[$];
        exp_t  e;
        s.push_back(st(4'b0100, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0100, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0100, 0, 0, 0, 4'h0, 4'b0100, 1, 4'h0));
        s.push_back(st(4'b0100, 1, 2, 0, 4'h0, 4'b0000, 0, 4'h0));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0100, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0000, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0));
        foreach (s[k]) begin
            apply(s[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (pending !== e.pend || req_valid !== e.rv || overflow !== e.ovf) begin
                errors++;
                $display("FAIL edge_latency step %0d: got pend=%b rv=%b ovf=%b, want pend=%b rv=%b ovf=%b",
                         k, pending, req_valid, overflow, e.pend, e.rv, e.ovf);
            end
        end
    endtask

    task automatic test_multi_ack();
        step_t s[$];
        exp_t  e;
        s.push_back(st(4'b1001, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b1001, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b1001, 0, 0, 0, 4'h0, 4'b1001, 1, 4'h0));
        s.push_back(st(4'b1001, 1, 3, 0, 4'h0, 4'b0001, 1, 4'h0));
        s.push_back(st(4'b1001, 1, 1, 0, 4'h0, 4'b0001, 1, 4'h0));
        s.push_back(st(4'b1001, 0, 3, 0, 4'h0, 4'b0001, 1, 4'h0));
        s.push_back(st(4'b1001, 1, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0000, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0));
        foreach (s[k]) begin
            apply(s[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (pending !== e.pend || req_valid !== e.rv || overflow !== e.ovf) begin
                errors++;
                $display("FAIL multi_ack step %0d: got pend=%b rv=%b ovf=%b, want pend=%b rv=%b ovf=%b",
                         k, pending, req_valid, overflow, e.pend, e.rv, e.ovf);
            end
        end
    endtask

    task automatic test_overflow();
        step_t s[$];
        exp_t  e;
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'h0));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0000, 0, 0, 0, 4'h0, 4'b0010, 1, 4'h0));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'b0000));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'b0000));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'b0010));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'b0010));
        s.push_back(st(4'b0010, 0, 0, 1, 4'h0, 4'b0010, 1, 4'b0000));
        s.push_back(st(4'b0010, 1, 1, 0, 4'h0, 4'b0000, 0, 4'b0000));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0000, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0));
        foreach (s[k]) begin
            apply(s[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (pending !== e.pend || req_valid !== e.rv || overflow !== e.ovf) begin
                errors++;
                $display("FAIL overflow step %0d: got pend=%b rv=%b ovf=%b, want pend=%b rv=%b ovf=%b",
                         k, pending, req_valid, overflow, e.pend, e.rv, e.ovf);
            end
        end
    endtask

    task automatic test_mask();
        step_t s[$];
        exp_t  e;
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0010, 0, 0, 0, 4'b0010, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0010, 0, 0, 0, 4'b0000, 4'b0010, 1, 4'h0));
        s.push_back(st(4'b0010, 1, 1, 0, 4'b0000, 4'b0000, 0, 4'h0));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0000, 0, 0, 0, 4'b0000, 4'h0, 0, 4'h0));
        // masked bit acknowledged while hidden stays cleared once unmasked
        for (int i = 0; i < 3; i++) s.push_back(st(4'b0010, 0, 0, 0, 4'b0010, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0010, 1, 1, 0, 4'b0010, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 0, 4'h0));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0000, 0, 0, 0, 4'b0000, 4'h0, 0, 4'h0));
        foreach (s[k]) begin
            apply(s[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (pending !== e.pend || req_valid !== e.rv || overflow !== e.ovf) begin
                errors++;
                $display("FAIL mask step %0d: got pend=%b rv=%b ovf=%b, want pend=%b rv=%b ovf=%b",
                         k, pending, req_valid, overflow, e.pend, e.rv, e.ovf);
            end
        end
    endtask

    task automatic test_set_clear();
        step_t s[$];
        exp_t  e;
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'h0));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0000, 0, 0, 0, 4'h0, 4'b0010, 1, 4'h0));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'h0));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'h0));
        s.push_back(st(4'b0010, 1, 1, 0, 4'h0, 4'b0010, 1, 4'b0000));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'b0000));
        s.push_back(st(4'b0010, 1, 1, 0, 4'h0, 4'b0000, 0, 4'b0000));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0000, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0));
        foreach (s[k]) begin
            apply(s[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (pending !== e.pend || req_valid !== e.rv || overflow !== e.ovf) begin
                errors++;
                $display("FAIL set_clear step %0d: got pend=%b rv=%b ovf=%b, want pend=%b rv=%b ovf=%b",
                         k, pending, req_valid, overflow, e.pend, e.rv, e.ovf);
            end
        end
    endtask

    task automatic test_level();
        step_t s[$];
        exp_t  e;
        for (int i = 0; i < 3; i++) s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'b0000));
        s.push_back(st(4'b0010, 0, 0, 0, 4'h0, 4'b0010, 1, 4'b0010));
        s.push_back(st(4'b0010, 1, 1, 0, 4'h0, 4'b0010, 1, 4'b0010));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0000, 0, 0, 0, 4'h0, 4'b0010, 1, 4'b0010));
        s.push_back(st(4'b0000, 1, 1, 0, 4'h0, 4'b0000, 0, 4'b0010));
        s.push_back(st(4'b0000, 0, 0, 1, 4'h0, 4'b0000, 0, 4'b0000));
        s.push_back(st(4'b0000, 0, 0, 0, 4'h0, 4'b0000, 0, 4'b0000));
        foreach (s[k]) begin
            apply(s[k], 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (pend_l !== e.pend || rv_l !== e.rv || ovf_l !== e.ovf) begin
                errors++;
                $display("FAIL level step %0d: got pend=%b rv=%b ovf=%b, want pend=%b rv=%b ovf=%b",
                         k, pend_l, rv_l, ovf_l, e.pend, e.rv, e.ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        step_t t[$];
        exp_t  e;
        s.push_back(st(4'b1000, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b1000, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b1000, 0, 0, 0, 4'h0, 4'b1000, 1, 4'h0));
        s.push_back(st(4'b1001, 0, 0, 0, 4'h0, 4'b1000, 1, 4'h0));
        foreach (s[k]) begin
            apply(s[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (pending !== e.pend || req_valid !== e.rv || overflow !== e.ovf) begin
                errors++;
                $display("FAIL reset_mid_pre step %0d: got pend=%b rv=%b ovf=%b, want pend=%b rv=%b ovf=%b",
                         k, pending, req_valid, overflow, e.pend, e.rv, e.ovf);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({pending, req_valid, overflow} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got pend=%b rv=%b ovf=%b, want all 0",
                     pending, req_valid, overflow);
        end
        irq_e = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) t.push_back(st(4'b0000, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0));
        foreach (t[k]) begin
            apply(t[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (pending !== e.pend || req_valid !== e.rv || overflow !== e.ovf) begin
                errors++;
                $display("FAIL reset_mid_post step %0d: got pend=%b rv=%b ovf=%b, want pend=%b rv=%b ovf=%b",
                         k, pending, req_valid, overflow, e.pend, e.rv, e.ovf);
            end
        end
    endtask

    task automatic test_reset_held_high();
        step_t s[$];
        exp_t  e;
        rst = 1'b1;
        irq_e = 4'b0100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s.push_back(st(4'b0100, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0100, 0, 0, 0, 4'h0, 4'b0000, 0, 4'h0));
        s.push_back(st(4'b0100, 0, 0, 0, 4'h0, 4'b0100, 1, 4'h0));
        s.push_back(st(4'b0100, 1, 2, 0, 4'h0, 4'b0000, 0, 4'h0));
        for (int i = 0; i < 4; i++) s.push_back(st(4'b0100, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0));
        for (int i = 0; i < 2; i++) s.push_back(st(4'b0000, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0));
        foreach (s[k]) begin
            apply(s[k], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (pending !== e.pend || req_valid !== e.rv || overflow !== e.ovf) begin
                errors++;
                $display("FAIL reset_held step %0d: got pend=%b rv=%b ovf=%b, want pend=%b rv=%b ovf=%b",
                         k, pending, req_valid, overflow, e.pend, e.rv, e.ovf);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_edge_latency();
        test_multi_ack();
        test_overflow();
        test_mask();
        test_set_clear();
        test_level();
        test_reset_mid();
        test_reset_held_high();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
